ld_st_mem_if: RTL and testbench



---
 rtl/ld_st_mem_if.sv | 174 +++++++++++++++++
 tb/tb_ld_st_mem_if.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ld_st_mem_if.sv
// Load/store memory-access stage: runs one single-beat bus transaction
// per request, builds byte enables / lane data, extends load results.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, is_load, size,    request pulse and its attributes
//   sign_ext, addr, wdata
//   busy, done, fault,       status to the core sequencer
//   rd_data                  extended load result, held after done
//   mem_req, mem_we,         word-wide bus request side
//   mem_addr, mem_be,
//   mem_wdata
//   mem_rdata, mem_ack       bus response side
module ld_st_mem_if #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rd_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FIN
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ld_q;
  logic          sext_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;

  logic          bad;
  logic [3:0]    be_c;
  logic [31:0]   wd_c;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ext;

  // request decode from the live inputs (used only in IDLE)
  always_comb begin
    bad  = 1'b0;
    be_c = 4'b0000;
    wd_c = wdata;
    unique case (size)
      2'b00: begin
        be_c = 4'b0001 << addr[1:0];
        wd_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        bad  = addr[0];
        be_c = addr[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{wdata[15:0]}};
      end
      2'b10: begin
        bad  = (addr[1:0] != 2'b00);
        be_c = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  // lane select and extension of the returned word
  always_comb begin
    unique case (off_q)
      2'b00:   lane_b = mem_rdata[7:0];
      2'b01:   lane_b = mem_rdata[15:8];
      2'b10:   lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'b00:   ext = {{24{sext_q & lane_b[7]}}, lane_b};
      2'b01:   ext = {{16{sext_q & lane_h[15]}}, lane_h};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ld_q      <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rd_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (start) begin
            ld_q   <= is_load;
            sext_q <= sign_ext;
            size_q <= size;
            off_q  <= addr[1:0];
            busy   <= 1'b1;
            if (bad) begin
              state <= FIN;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= !is_load;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wd_c;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (ld_q) rd_data <= ext;
            state   <= FIN;
            done    <= 1'b1;
            fault   <= 1'b0;
            mem_req <= 1'b0;
            mem_be  <= '0;
          end else if (TIMEOUT != 0 && cnt == LAST) begin
            // bus never answered: abort and report
            state   <= FIN;
            done    <= 1'b1;
            fault   <= 1'b1;
            mem_req <= 1'b0;
            mem_be  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ld_st_mem_if.sv
// Directed self-checking bench for ld_st_mem_if.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ld_st_mem_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rd_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int compared = 0;
  int mismatched = 0;
  int n;

  always #5 clk = ~clk;

  ld_st_mem_if #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .fault(fault), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one-cycle start pulse; returns sampled in the cycle after the edge
  task automatic launch(input logic ld, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a,
                        input logic [31:0] wd);
    is_load  = ld;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; is_load = 1'b1; size = 2'b10;
    sign_ext = 1'b0; addr = 32'h10; wdata = 32'hFFFF_FFFF;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_fault", {31'b0, fault}, 0);
    check("rst_rd", rd_data, 0);
    check("rst_req", {31'b0, mem_req}, 0);
    check("rst_we", {31'b0, mem_we}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", {28'b0, mem_be}, 0);
    check("rst_wd", mem_wdata, 0);

    // reset in the middle of a request
    start = 1'b0;
    rst = 1'b1;
    tick();
    launch(1, 2'b10, 0, 32'h3000, 0);
    check("mid_req_on", {31'b0, mem_req}, 1);
    rst = 1'b0;
    tick();
    check("mid_req_off", {31'b0, mem_req}, 0);
    check("mid_busy", {31'b0, busy}, 0);
    rst = 1'b1;
    tick();
    check("mid_nodone", {31'b0, done}, 0);
    tick();
    check("mid_nodone2", {31'b0, done}, 0);

    // store byte, ack on second REQ cycle
    launch(0, 2'b00, 0, 32'h1003, 32'h0000_00A5);
    check("sb_req", {31'b0, mem_req}, 1);
    check("sb_we", {31'b0, mem_we}, 1);
    check("sb_addr", mem_addr, 32'h1000);
    check("sb_be", {28'b0, mem_be}, 32'h8);
    check("sb_wd", mem_wdata, 32'hA5A5_A5A5);
    check("sb_busy", {31'b0, busy}, 1);
    tick();
    check("sb_req2", {31'b0, mem_req}, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_done", {31'b0, done}, 1);
    check("sb_fault", {31'b0, fault}, 0);
    check("sb_req_off", {31'b0, mem_req}, 0);
    check("sb_be_off", {28'b0, mem_be}, 0);
    check("sb_rd_kept", rd_data, 0);
    tick();
    check("sb_done_off", {31'b0, done}, 0);
    check("sb_idle", {31'b0, busy}, 0);

    // load half signed at upper lane
    launch(1, 2'b01, 1, 32'h2002, 0);
    check("lhs_be", {28'b0, mem_be}, 32'hC);
    check("lhs_we", {31'b0, mem_we}, 0);
    check("lhs_addr", mem_addr, 32'h2000);
    mem_rdata = 32'h8001_1234;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lhs_done", {31'b0, done}, 1);
    check("lhs_rd", rd_data, 32'hFFFF_8001);
    tick();
    check("lhs_hold", rd_data, 32'hFFFF_8001);

    // same, zero-extended
    launch(1, 2'b01, 0, 32'h2002, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lhu_rd", rd_data, 32'h0000_8001);
    tick();

    // load byte unsigned at lane 1
    launch(1, 2'b00, 0, 32'h41, 0);
    check("lbu_be", {28'b0, mem_be}, 32'h2);
    check("lbu_addr", mem_addr, 32'h40);
    mem_rdata = 32'h11F2_3344;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lbu_rd", rd_data, 32'h0000_0033);
    tick();

    // store half and store word lane data
    launch(0, 2'b01, 0, 32'h6, 32'h1234_BEEF);
    check("sh_be", {28'b0, mem_be}, 32'hC);
    check("sh_wd", mem_wdata, 32'hBEEF_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    launch(0, 2'b10, 0, 32'h8, 32'h1234_5678);
    check("sw_be", {28'b0, mem_be}, 32'hF);
    check("sw_wd", mem_wdata, 32'h1234_5678);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sw_rd_kept", rd_data, 32'h0000_0033);
    tick();

    // faults: misaligned word, misaligned half, illegal size
    launch(1, 2'b10, 0, 32'h2, 0);
    check("mw_done", {31'b0, done}, 1);
    check("mw_fault", {31'b0, fault}, 1);
    check("mw_req", {31'b0, mem_req}, 0);
    check("mw_rd", rd_data, 32'h0000_0033);
    tick();
    check("mw_done_off", {31'b0, done}, 0);
    launch(1, 2'b01, 0, 32'h1, 0);
    check("mh_fault", {31'b0, fault}, 1);
    check("mh_req", {31'b0, mem_req}, 0);
    tick();
    launch(0, 2'b11, 0, 32'h0, 0);
    check("il_done", {31'b0, done}, 1);
    check("il_fault", {31'b0, fault}, 1);
    check("il_req", {31'b0, mem_req}, 0);
    tick();

    // timeout with a stray start while busy
    launch(1, 2'b10, 0, 32'h100, 0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      start = (n == 5);
      addr  = 32'h2;
      check("to_addr", mem_addr, 32'h100);
      tick();
    end
    start = 1'b0;
    check("to_cycles", n, 16);
    check("to_done", {31'b0, done}, 1);
    check("to_fault", {31'b0, fault}, 1);
    check("to_rd", rd_data, 32'h0000_0033);
    tick();
    tick();
    check("to_noqueue", {31'b0, busy}, 0);
    check("to_nodone", {31'b0, done}, 0);

    // ack on the last allowed cycle wins
    launch(1, 2'b10, 0, 32'h104, 0);
    mem_rdata = 32'hCAFE_F00D;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      mem_ack = (n == 16);
      tick();
    end
    mem_ack = 1'b0;
    check("ack16_cycles", n, 16);
    check("ack16_done", {31'b0, done}, 1);
    check("ack16_fault", {31'b0, fault}, 0);
    check("ack16_rd", rd_data, 32'hCAFE_F00D);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
